// File: rtl/cpu_mc_pkg.sv
// Shared types for the cpu_mc multi-cycle core: opcodes, FSM states and flag bit positions.
package cpu_mc_pkg;

  typedef enum logic [3:0] {
    OpNop  = 4'h0,
    OpAdd  = 4'h1,
    OpSub  = 4'h2,
    OpAnd  = 4'h3,
    OpOr   = 4'h4,
    OpXor  = 4'h5,
    OpShl  = 4'h6,
    OpShr  = 4'h7,
    OpLdi  = 4'h8,
    OpLd   = 4'h9,
    OpSt   = 4'hA,
    OpBz   = 4'hB,
    OpJmp  = 4'hC,
    OpBc   = 4'hD,
    OpCmp  = 4'hE,
    OpHalt = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    StBoot,
    StFetch,
    StExec,
    StMem,
    StHalt
  } state_e;

  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_N = 0;

  function automatic logic sets_flags(opcode_e op);
    return ((op >= OpAdd) && (op <= OpShr)) || (op == OpCmp);
  endfunction

endpackage

// File: rtl/cpu_mc_if.sv
// Instruction and data memory buses of cpu_mc; the core is master, memories are slave.
interface cpu_mc_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned INST_W = 16
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic [INST_W-1:0] imem_rdata;
  logic              imem_ready;

  logic              dmem_req;
  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic [DATA_W-1:0] dmem_rdata;
  logic              dmem_ready;

  modport master (
    output imem_req, imem_addr,
    input  imem_rdata, imem_ready,
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_rdata, dmem_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_rdata, imem_ready,
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_rdata, dmem_ready
  );
endinterface

// File: rtl/cpu_mc_regfile.sv
// cpu_mc register file: two async read ports, one sync write port, async clear.
// Define CPU_MC_R0_ZERO_EN to hard-wire register 0 to zero.
module cpu_mc_regfile #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned REG_AW = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [REG_AW-1:0] raddr_a_i,
  output logic [DATA_W-1:0] rdata_a_o,
  input  logic [REG_AW-1:0] raddr_b_i,
  output logic [DATA_W-1:0] rdata_b_o,
  input  logic              we_i,
  input  logic [REG_AW-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i
);
  localparam int unsigned NumRegs = 2 ** REG_AW;

  logic [DATA_W-1:0] regs_q [NumRegs];
  logic [DATA_W-1:0] regs_d [NumRegs];

  always_comb begin
    regs_d = regs_q;
`ifdef CPU_MC_R0_ZERO_EN
    if (we_i && (waddr_i != '0)) regs_d[waddr_i] = wdata_i;
`else
    if (we_i) regs_d[waddr_i] = wdata_i;
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) regs_q <= '{default: '0};
    else         regs_q <= regs_d;
  end

`ifdef CPU_MC_R0_ZERO_EN
  assign rdata_a_o = (raddr_a_i == '0) ? '0 : regs_q[raddr_a_i];
  assign rdata_b_o = (raddr_b_i == '0) ? '0 : regs_q[raddr_b_i];
`else
  assign rdata_a_o = regs_q[raddr_a_i];
  assign rdata_b_o = regs_q[raddr_b_i];
`endif

endmodule

// File: rtl/cpu_mc.sv
// Multi-cycle CPU core: BOOT/FETCH/EXEC/MEM/HALT FSM over req/ready memory ports.
// Optional build macro CPU_MC_R0_ZERO_EN (see cpu_mc_regfile) makes r0 constant zero.
module cpu_mc
  import cpu_mc_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned REG_AW = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  cpu_mc_if.master          bus,
  output logic              halted,
  output logic [ADDR_W-1:0] pc_o,
  output logic [2:0]        flags_o
);
  localparam int unsigned INST_W = 4 + 3 * REG_AW;
  localparam int unsigned IMM_W  = 2 * REG_AW;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [INST_W-1:0] ir_q, ir_d;
  logic [2:0]        flags_q, flags_d;

  opcode_e           op;
  logic [REG_AW-1:0] rd, rs1, rs2;
  logic [IMM_W-1:0]  imm;
  logic [DATA_W-1:0] rdata_a, rdata_b, rf_wdata;
  logic              rf_we;
  logic [DATA_W:0]   alu_res;

  assign op  = opcode_e'(ir_q[INST_W-1 -: 4]);
  assign rd  = ir_q[INST_W-5 -: REG_AW];
  assign rs1 = ir_q[INST_W-5-REG_AW -: REG_AW];
  assign rs2 = ir_q[REG_AW-1:0];
  assign imm = ir_q[IMM_W-1:0];

  // Bit DATA_W carries the C flag: carry, borrow, or the bit shifted out.
  function automatic logic [DATA_W:0] alu(opcode_e f, logic [DATA_W-1:0] a,
                                          logic [DATA_W-1:0] b);
    case (f)
      OpAdd:        return {1'b0, a} + {1'b0, b};
      OpSub, OpCmp: return {1'b0, a} - {1'b0, b};
      OpAnd:        return {1'b0, a & b};
      OpOr:         return {1'b0, a | b};
      OpXor:        return {1'b0, a ^ b};
      OpShl:        return {a, 1'b0};
      OpShr:        return {a[0], 1'b0, a[DATA_W-1:1]};
      default:      return '0;
    endcase
  endfunction

  // Port B serves store data (rd) for ST and the second ALU operand otherwise.
  cpu_mc_regfile #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW)
  ) u_regfile (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .raddr_a_i (rs1),
    .rdata_a_o (rdata_a),
    .raddr_b_i ((op == OpSt) ? rd : rs2),
    .rdata_b_o (rdata_b),
    .we_i      (rf_we),
    .waddr_i   (rd),
    .wdata_i   (rf_wdata)
  );

  assign alu_res = alu(op, rdata_a, rdata_b);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    flags_d  = flags_q;
    rf_we    = 1'b0;
    rf_wdata = alu_res[DATA_W-1:0];
    unique case (state_q)
      StBoot: state_d = StFetch;
      StFetch: begin
        if (bus.imem_ready) begin
          ir_d    = bus.imem_rdata;
          pc_d    = pc_q + ADDR_W'(1);
          state_d = StExec;
        end
      end
      StExec: begin
        state_d = StFetch;
        if (sets_flags(op)) begin
          flags_d[FLAG_Z] = (alu_res[DATA_W-1:0] == '0);
          flags_d[FLAG_C] = alu_res[DATA_W];
          flags_d[FLAG_N] = alu_res[DATA_W-1];
        end
        case (op)
          OpAdd, OpSub, OpAnd, OpOr, OpXor, OpShl, OpShr: rf_we = 1'b1;
          OpLdi: begin
            rf_we    = 1'b1;
            rf_wdata = DATA_W'(imm);
          end
          OpLd, OpSt: state_d = StMem;
          OpBz:   if (flags_q[FLAG_Z]) pc_d = ADDR_W'(imm);
          OpJmp:  pc_d = ADDR_W'(imm);
          OpBc:   if (flags_q[FLAG_C]) pc_d = ADDR_W'(imm);
          OpHalt: state_d = StHalt;
          default: ;
        endcase
      end
      StMem: begin
        if (bus.dmem_ready) begin
          state_d = StFetch;
          if (op == OpLd) begin
            rf_we    = 1'b1;
            rf_wdata = bus.dmem_rdata;
          end
        end
      end
      StHalt: ;
      default: state_d = StBoot;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StBoot;
      pc_q    <= '0;
      ir_q    <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      flags_q <= flags_d;
    end
  end

  assign bus.imem_req   = (state_q == StFetch);
  assign bus.imem_addr  = pc_q;
  assign bus.dmem_req   = (state_q == StMem);
  assign bus.dmem_we    = (state_q == StMem) && (op == OpSt);
  assign bus.dmem_addr  = ADDR_W'(rdata_a);
  assign bus.dmem_wdata = rdata_b;
  assign halted         = (state_q == StHalt);
  assign pc_o           = pc_q;
  assign flags_o        = flags_q;

endmodule

// File: doc/cpu_mc.md
Name: cpu_mc

Overview:
- Parametrised multi-cycle successor of the single-cycle CPU top.
- Runs a FETCH/EXEC/MEM state machine against separate instruction and data memory ports, each with a req/ready handshake, so memories may insert wait states.
- Adds Z/C/N flags, conditional and unconditional branches, compare, and halt.
- Generalises data width, address width and register count.

Parameters:
- DATA_W, 8, datapath and register width (>=4).
- ADDR_W, 8, PC and data address width.
- REG_AW, 4, register index width; 2**REG_AW registers.
- localparam INST_W = 4 + 3*REG_AW. Layout: [INST_W-1 -: 4] opcode, then rd, rs1, rs2.
- localparam IMM_W = 2*REG_AW. IMM is {rs1,rs2}, zero-extended or truncated to the destination width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  ADDR_W  fetch address (= PC).
- imem_rdata  in  INST_W  instruction; valid when imem_ready=1.
- imem_ready  in  1  fetch complete.
- dmem_req  out  1  data request.
- dmem_we  out  1  1 = store, 0 = load.
- dmem_addr  out  ADDR_W  data address (= reg[rs1] truncated or zero-extended).
- dmem_wdata  out  DATA_W  store data (= reg[rd]).
- dmem_rdata  in  DATA_W  load data; valid when dmem_ready=1.
- dmem_ready  in  1  data transaction complete.
- halted  out  1  core executed HALT.
- pc_o  out  ADDR_W  current PC.
- flags_o  out  3  {Z,C,N}.

Behaviour:
- Reset (async, rst_n=0):
  - state=BOOT; PC=0; flags=0; instruction register=0; all registers=0.
  - All outputs 0.
  - Reset mid-transaction abandons it; no register or flag update occurs.
- FSM:
  - BOOT -> FETCH unconditionally (one cycle, req low).
  - FETCH: imem_req=1, imem_addr=PC. On an edge with imem_ready=1, latch the instruction, PC<=PC+1 (wraps mod 2**ADDR_W), -> EXEC. Otherwise stay; address must remain stable.
  - EXEC: decode and execute. LD/ST -> MEM. HALT -> HALT. All others -> FETCH.
  - MEM: dmem_req=1, dmem_we=(op==ST). On an edge with dmem_ready=1: LD writes dmem_rdata to rd; -> FETCH.
  - HALT: halted=1, all req low, stay until reset.
- Handshake:
  - req is a combinational function of state.
  - ready may be high in the same cycle req rises; that gives a zero-wait transfer.
  - ready while req=0 is ignored.
- Latency with zero-wait memories:
  - ALU/LDI/branch/NOP: 2 cycles.
  - LD/ST: 3 cycles.
- Opcodes:
  - 0 NOP
  - 1 ADD
  - 2 SUB
  - 3 AND
  - 4 OR
  - 5 XOR
  - 6 SHL (by 1)
  - 7 SHR (logical, by 1)
  - 8 LDI: rd<=IMM
  - 9 LD: rd<=mem[rs1]
  - A ST: mem[rs1]<=rd
  - B BZ: if Z then PC<=IMM
  - C JMP: PC<=IMM
  - D BC: if C then PC<=IMM
  - E CMP: rs1-rs2, flags only
  - F HALT
  - ALU ops: rd <= rs1 op rs2, mod 2**DATA_W.
- Flags: updated only by ops 1-7 and E. Z = result==0. N = result MSB. C as follows:
  - ADD: carry out.
  - SUB/CMP: borrow (rs1<rs2 unsigned).
  - Logic ops: 0.
  - SHL: old MSB.
  - SHR: old LSB.
- Simultaneous read/write: rd==rs1 within one instruction reads the old value; the write lands at the end of EXEC.
- Branch target: the taken branch overrides the PC+1 already applied in FETCH. A not-taken branch leaves PC unchanged.

Optional Feature:
- Macro: CPU_MC_R0_ZERO_EN.
- Defined: register 0 reads as 0 and writes to it are discarded.
- Undefined: register 0 is an ordinary register.

Decomposition:
- Package cpu_mc_pkg holds:
  - opcode enum (4-bit)
  - state enum {BOOT, FETCH, EXEC, MEM, HALT}
  - flag bit indices FLAG_Z=2, FLAG_C=1, FLAG_N=0
- Sub-module cpu_mc_regfile:
  - 2 async read ports, 1 sync write port, async reset clear.
  - Honours CPU_MC_R0_ZERO_EN.
- ALU stays inline as a combinational function.

Test Plan:
- Zero-wait program LDI r1,5; LDI r2,3; ADD r3,r1,r2; HALT -> r3=8, flags=000, halted=1 at cycle 9 after reset release (BOOT + 4x2).
- SUB r3,r2,r1 with r2=3, r1=5 -> r3=0xFE, C=1, N=1, Z=0. Then CMP r1,r1 -> Z=1, C=0, registers unchanged.
- imem_ready held low for 3 cycles during the fetch at PC=2 -> imem_addr stays 2 and imem_req stays high throughout; execution resumes with a correct result; dmem_req never asserted.
- ST mem[r1]<=r3 with r1=0x10, r3=0x8 -> dmem_req=1, dmem_we=1, addr=0x10, wdata=0x08. Then LD r4,[r1] with rdata=0x5A after 2 wait cycles -> r4=0x5A.
- BZ after a CMP that set Z=1, target IMM=0x20 -> next imem_addr=0x20. With Z=0, next imem_addr = branch PC+1. JMP from PC=0xFF to IMM=0x00 -> PC wraps correctly.
- rst_n pulled low mid-MEM (dmem_req=1) -> all outputs 0 immediately, PC=0. After release: one BOOT cycle, then FETCH at address 0. With CPU_MC_R0_ZERO_EN defined, LDI r0,7 then ADD r1,r0,r0 -> r1=0.
